// File: rtl/mips_multicycle_core_if.sv
// Host/debug/status bundle of mips_multicycle_core: program load, start, debug read, run status.
// master = host side (drives load/start/debug select), slave = core side.
interface mips_multicycle_core_if #(
  parameter int DATA_W     = 8,
  parameter int REG_AW     = 1,
  parameter int OFF_W      = 3,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32
);
  localparam int PC_W    = $clog2(IMEM_DEPTH);
  localparam int DA_W    = $clog2(DMEM_DEPTH);
  localparam int AW      = (PC_W > DA_W) ? PC_W : DA_W;
  localparam int INSTR_W = 3 + 2 * REG_AW + OFF_W;
  localparam int HW      = (INSTR_W > DATA_W) ? INSTR_W : DATA_W;

  logic              start;
  logic              host_we;
  logic              host_sel;
  logic [AW-1:0]     host_addr;
  logic [HW-1:0]     host_wdata;
  logic [REG_AW-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic [PC_W-1:0]   pc;
  logic [2:0]        state;
  logic              busy;
  logic              halted;
  logic [15:0]       retired;

  modport master (
    output start, host_we, host_sel, host_addr, host_wdata, dbg_sel,
    input  dbg_data, pc, state, busy, halted, retired
  );

  modport slave (
    input  start, host_we, host_sel, host_addr, host_wdata, dbg_sel,
    output dbg_data, pc, state, busy, halted, retired
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle load/store/add/sub core, one FSM state per clock (LOAD 5, ADD/SUB/STORE 4, NOP/HALT 2 cycles).
// Host writes and start are ignored while busy; MIPS_CORE_BRANCH_EN turns opcode 101 into BEQ.
module mips_multicycle_core #(
  parameter int DATA_W     = 8,
  parameter int REG_AW     = 1,
  parameter int OFF_W      = 3,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_multicycle_core_if.slave bus
);
  localparam int PC_W    = $clog2(IMEM_DEPTH);
  localparam int DA_W    = $clog2(DMEM_DEPTH);
  localparam int INSTR_W = 3 + 2 * REG_AW + OFF_W;
  localparam int NREG    = 1 << REG_AW;

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]  regs [NREG];

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  a_q, b_q, alu_q, mdr_q;
  logic [DA_W-1:0]    addr_q;
  logic [15:0]        retired_q;

  logic [2:0]        op;
  logic [REG_AW-1:0] ra, rb;
  logic [OFF_W-1:0]  off;
  logic idle_like, accept, host_wr, exec_op, retire, dmem_we, reg_we;

  assign op  = ir[INSTR_W-1 -: 3];
  assign ra  = ir[OFF_W+REG_AW +: REG_AW];
  assign rb  = ir[OFF_W +: REG_AW];
  assign off = ir[OFF_W-1:0];

  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign accept    = idle_like && bus.start;
  assign host_wr   = idle_like && bus.host_we;

`ifdef MIPS_CORE_BRANCH_EN
  logic take_branch;
  assign exec_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) ||
                   (op == OP_SUB) || (op == OP_BEQ);
  assign take_branch = (state_q == S_EXEC) && (op == OP_BEQ) && (a_q == b_q);
`else
  assign exec_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    dmem_we = 1'b0;
    reg_we  = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: if (bus.start) state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_HALT) state_d = S_HALTED;
        else if (exec_op)  state_d = S_EXEC;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        if ((op == OP_LOAD) || (op == OP_STORE))   state_d = S_MEM;
        else if ((op == OP_ADD) || (op == OP_SUB)) state_d = S_WB;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (op == OP_STORE) begin
          dmem_we = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      addr_q    <= '0;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (accept) pc_q <= '0;
      if (state_q == S_FETCH) begin
        ir   <= imem[pc_q];
        pc_q <= pc_q + PC_W'(1);
      end
      if (state_q == S_DECODE) begin
        a_q <= regs[ra];
        b_q <= regs[rb];
      end
      if (state_q == S_EXEC) begin
        alu_q  <= (op == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
        // Address arithmetic wraps at DMEM_DEPTH regardless of DATA_W.
        addr_q <= DA_W'(b_q) + DA_W'($signed(off));
      end
`ifdef MIPS_CORE_BRANCH_EN
      if (take_branch) pc_q <= pc_q + PC_W'($signed(off));
`endif
      if ((state_q == S_MEM) && (op == OP_LOAD)) mdr_q <= dmem[addr_q];
      if (reg_we) regs[ra] <= (op == OP_LOAD) ? mdr_q : alu_q;
      if (retire && (retired_q != 16'hFFFF)) retired_q <= retired_q + 16'd1;
    end
  end

  // Memory contents survive reset, so these arrays sit outside the reset domain.
  always_ff @(posedge clk) begin
    if (host_wr && !bus.host_sel)
      imem[bus.host_addr[PC_W-1:0]] <= bus.host_wdata[INSTR_W-1:0];
    if (dmem_we)
      dmem[addr_q] <= a_q;
    else if (host_wr && bus.host_sel)
      dmem[bus.host_addr[DA_W-1:0]] <= bus.host_wdata[DATA_W-1:0];
  end

  assign bus.dbg_data = regs[bus.dbg_sel];
  assign bus.pc       = pc_q;
  assign bus.state    = state_q;
  assign bus.busy     = !idle_like;
  assign bus.halted   = (state_q == S_HALTED);
  assign bus.retired  = retired_q;
endmodule
